reg_led_viewer: RTL and testbench
=================================

# reg_led_viewer

- Parametrised register viewer: drives a narrow LED bank with a selected slice of one of NUM_REGS debug registers.
- Selection comes from active-low push keys, one key per register. Keys are synchronised and debounced.
- Repeated presses of the same key step through the register's LED_W-wide slices.
- Sits at the board-I/O edge, beside the CPU register file. It is the multi-register, wide-register successor of the fixed four-register LED output stage.

## Interface
Parameters:
- NUM_REGS, 4, number of viewable registers (≥2)
- REG_W, 8, register width; must be a multiple of LED_W
- LED_W, 4, LED bank width
- DEBOUNCE_CYCLES, 16, stable cycles needed to accept a key level change (≥2)
- SCAN_PERIOD, 50000000, cycles per register in auto-scan (≥2; only used with LED_AUTOSCAN_EN)

Derived values:
- NSLICE = REG_W/LED_W
- SW = max(1, clog2(NUM_REGS))
- NW = max(1, clog2(NSLICE))

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_in  in  NUM_REGS  raw push keys, active-low, asynchronous to clk
- regs  in  NUM_REGS*REG_W  flattened registers; register i is regs[i*REG_W +: REG_W]
- scan_en  in  1  auto-scan request; ignored unless LED_AUTOSCAN_EN
- led_out  out  LED_W  displayed slice
- sel_out  out  SW  currently selected register index
- nib_out  out  NW  currently selected slice index (0 = least significant)

## Operation
- **Synchroniser:** each key_in bit goes through a 2-flop synchroniser.
- **Debouncer:** one per key.
  - Holds a debounced level, which resets to 1 (released).
  - Holds a counter that counts consecutive cycles where the synchronised level differs from the debounced level. The counter clears whenever the levels agree.
  - The debounced level flips once the mismatch has persisted DEBOUNCE_CYCLES cycles.
- **Press event:** a debounced 1→0 transition. A release produces no event.
- **Selection update**, on a press event for key i:
  - If i ≠ sel_out: sel_out←i and nib_out←0.
  - If i = sel_out: nib_out←(nib_out+1) mod NSLICE. Wraps from NSLICE-1 to 0.
- **Simultaneous press events** in one cycle: the highest index wins. Other events in that cycle are discarded.
- **Held keys:** a key held indefinitely yields exactly one event.
- **led_out:** registered each cycle from the register and slice named by the current sel_out/nib_out. The LEDs therefore track live register contents with 1-cycle latency.
- **Reset:** when rst_n is low at a clk edge:
  - sel_out=0, nib_out=0, led_out=0.
  - All debounced levels=1, counters=0, synchronisers=1, scan timer=0.
  - A key held through reset produces no press until it has been released and pressed again.

## Timing
- key_in falls before edge k and stays low:
  - synchronised low after edge k+1
  - debounced level 0 after edge k+1+DEBOUNCE_CYCLES
  - sel_out/nib_out updated after edge k+2+DEBOUNCE_CYCLES
  - led_out updated after edge k+3+DEBOUNCE_CYCLES
- **Glitch rejection:** a low pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- **Bounce during release:** bounce shorter than DEBOUNCE_CYCLES produces no second event.
- **Register-content change:** appears on led_out one edge after it appears on regs, when selected.
- **Reset mid-debounce:** discards the partial count. No event follows from that press.

## Configuration
LED_AUTOSCAN_EN:
- **Defined:**
  - While scan_en=1, a scan timer counts 0..SCAN_PERIOD-1.
  - On wrap, sel_out←(sel_out+1) mod NUM_REGS and nib_out←0.
  - A press event in the same cycle as a wrap takes precedence and clears the timer.
  - Any press event clears the timer.
  - scan_en=0 holds the timer at 0.
- **Not defined:**
  - The scan_en port exists but is ignored.
  - No scan timer logic is synthesised.
  - Selection changes only on press events.

## Test plan
Parameters for all scenarios unless stated: NUM_REGS=4, REG_W=8, LED_W=4, DEBOUNCE_CYCLES=4; regs = {8'hD4, 8'hC3, 8'hB2, 8'hA1} for registers 3..0.

1. **Reset:** hold rst_n=0 for 3 edges, then release → sel_out=0, nib_out=0, led_out=0 during reset; led_out=4'h1 one edge after release.
2. **Basic press:** key_in[2] low from edge 10, held → sel_out=2 after edge 16, led_out=4'h3 after edge 17. Holding 100 more cycles causes no further change.
3. **Slice step:** press key 2 again after a full release → nib_out=1, led_out=4'hC. A third press → nib_out=0, led_out=4'h3 (wrap).
4. **Simultaneous press and glitch:**
   - key_in[0] and key_in[3] fall on the same edge → sel_out=3, led_out=4'h4.
   - A 3-cycle low glitch on key_in[1] → no change.
5. **Live update and reset mid-debounce:**
   - With sel_out=3, change regs[31:24] to 8'h7E → led_out=4'hE on the next edge.
   - Assert reset 2 cycles into a key press → no event after reset is released.
6. **Auto-scan (LED_AUTOSCAN_EN, SCAN_PERIOD=8):**
   - scan_en=1 → sel_out advances 0→1→2→3→0 every 8 cycles.
   - A press of key 2 mid-period → sel_out=2, timer cleared, next advance 8 cycles later.
   - Without the macro → sel_out stays 0.

Source files
------------

// File: rtl/reg_led_viewer.sv
// Register viewer: debounced active-low keys select a debug register and step through its LED_W-wide slices.
// Optional LED_AUTOSCAN_EN macro adds a timer that cycles the selection while scan_en is high.
module reg_led_viewer #(
    parameter int NUM_REGS        = 4,
    parameter int REG_W           = 8,
    parameter int LED_W           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_PERIOD     = 50000000,
    localparam int NSLICE = REG_W / LED_W,
    localparam int SW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int NW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REGS-1:0]       key_in,
    input  logic [NUM_REGS*REG_W-1:0] regs,
    input  logic                      scan_en,
    output logic [LED_W-1:0]          led_out,
    output logic [SW-1:0]             sel_out,
    output logic [NW-1:0]             nib_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_REGS-1:0] sync1;
    logic [NUM_REGS-1:0] sync2;
    logic [NUM_REGS-1:0] level;
    logic [NUM_REGS-1:0] armed;
    logic [NUM_REGS-1:0] press;
    logic [CW-1:0]       cnt [NUM_REGS];
    logic [1:0]          ready;

    // A key is armed only after it has been seen released once the synchroniser
    // has refilled, so a key held through reset cannot fire on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            armed <= '0;
            press <= '0;
            ready <= '0;
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            ready <= {ready[0], 1'b1};
            for (int i = 0; i < NUM_REGS; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                    press[i] <= ~sync2[i] & armed[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                if (ready[1] && level[i] && sync2[i]) armed[i] <= 1'b1;
            end
        end
    end

    logic          hit;
    logic [SW-1:0] hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (press[i]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

`ifdef LED_AUTOSCAN_EN
    localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    logic [TW-1:0] timer;
    logic          wrap;
    assign wrap = scan_en && (timer == TW'(SCAN_PERIOD - 1));
`else
    logic unused_scan;
    assign unused_scan = scan_en | (SCAN_PERIOD < 2);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_out <= '0;
            nib_out <= '0;
            led_out <= '0;
`ifdef LED_AUTOSCAN_EN
            timer   <= '0;
`endif
        end else begin
            led_out <= regs[int'(sel_out) * REG_W + int'(nib_out) * LED_W +: LED_W];
            if (hit) begin
                if (hit_idx == sel_out) begin
                    nib_out <= (nib_out == NW'(NSLICE - 1)) ? '0 : nib_out + 1'b1;
                end else begin
                    sel_out <= hit_idx;
                    nib_out <= '0;
                end
`ifdef LED_AUTOSCAN_EN
            end else if (wrap) begin
                sel_out <= (sel_out == SW'(NUM_REGS - 1)) ? '0 : sel_out + 1'b1;
                nib_out <= '0;
`endif
            end
`ifdef LED_AUTOSCAN_EN
            if (hit || !scan_en || wrap) timer <= '0;
            else                         timer <= timer + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_reg_led_viewer.sv
// Directed bench for reg_led_viewer: press/slice table plus timing, bounce, live-update and reset sequences.
// Build with LED_AUTOSCAN_EN defined to exercise the scan timer instead of the ignored-scan_en check.
module tb_reg_led_viewer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_in = 4'hF;
    logic [31:0] regs = 32'hD4C3B2A1;
    logic        scan_en = 1'b0;
    logic [3:0]  led_out;
    logic [1:0]  sel_out;
    logic        nib_out;

    int n_vec = 0;
    int n_bad = 0;

    reg_led_viewer #(
        .NUM_REGS(4), .REG_W(8), .LED_W(4), .DEBOUNCE_CYCLES(4), .SCAN_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .regs(regs), .scan_en(scan_en),
        .led_out(led_out), .sel_out(sel_out), .nib_out(nib_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] keys;
        int         low;
        logic [1:0] sel;
        logic       nib;
        logic [3:0] led;
    } vec_t;

    vec_t tbl [13];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] s, input logic n, input logic [3:0] l);
        n_vec++;
        if (sel_out !== s || nib_out !== n || led_out !== l) begin
            n_bad++;
            $display("FAIL %s: got sel=%0d nib=%0d led=%h, required sel=%0d nib=%0d led=%h",
                     name, sel_out, nib_out, led_out, s, n, l);
        end
    endtask

    task automatic press(input logic [3:0] pat, input int low);
        key_in = pat;
        tick(low);
        key_in = 4'hF;
        tick(12);
    endtask

    initial begin
        tbl[0]  = '{4'b1011, 10, 2'd2, 1'b1, 4'hC};
        tbl[1]  = '{4'b1011, 10, 2'd2, 1'b0, 4'h3};
        tbl[2]  = '{4'b0110, 10, 2'd3, 1'b0, 4'h4};
        tbl[3]  = '{4'b1101,  3, 2'd3, 1'b0, 4'h4};
        tbl[4]  = '{4'b0111, 10, 2'd3, 1'b1, 4'hD};
        tbl[5]  = '{4'b1101, 10, 2'd1, 1'b0, 4'h2};
        tbl[6]  = '{4'b1101, 10, 2'd1, 1'b1, 4'hB};
        tbl[7]  = '{4'b1110, 10, 2'd0, 1'b0, 4'h1};
        tbl[8]  = '{4'b1101,  4, 2'd1, 1'b0, 4'h2};
        tbl[9]  = '{4'b1000, 10, 2'd2, 1'b0, 4'h3};
        tbl[10] = '{4'b1110, 10, 2'd0, 1'b0, 4'h1};
        tbl[11] = '{4'b0111,  3, 2'd0, 1'b0, 4'h1};
        tbl[12] = '{4'b0111, 10, 2'd3, 1'b0, 4'h4};

        // Reset held for three edges, LEDs show reg0 low slice one edge after release.
        tick(3);
        check("in_reset", 2'd0, 1'b0, 4'h0);
        rst_n = 1'b1;
        tick(1);
        check("after_reset", 2'd0, 1'b0, 4'h1);
        tick(5);

        // Exact latency of a press: key low seen at edge k, selection at k+6, LEDs at k+7.
        key_in = 4'b1011;
        tick(6);
        check("press_k5", 2'd0, 1'b0, 4'h1);
        tick(1);
        check("press_k6", 2'd2, 1'b0, 4'h1);
        tick(1);
        check("press_k7", 2'd2, 1'b0, 4'h3);
        tick(100);
        check("held_key", 2'd2, 1'b0, 4'h3);
        key_in = 4'hF;
        tick(12);

        for (int v = 0; v < 13; v++) begin
            press(tbl[v].keys, tbl[v].low);
            check($sformatf("vec%0d", v), tbl[v].sel, tbl[v].nib, tbl[v].led);
        end

        // Bouncy release on key 3: only the original press may count.
        key_in = 4'b0111; tick(10);
        key_in = 4'hF;    tick(2);
        key_in = 4'b0111; tick(1);
        key_in = 4'hF;    tick(3);
        key_in = 4'b0111; tick(2);
        key_in = 4'hF;    tick(12);
        check("bounce_release", 2'd3, 1'b1, 4'hD);

        press(4'b0111, 10);
        check("wrap_slice", 2'd3, 1'b0, 4'h4);
        regs[31:24] = 8'h7E;
        #3;
        check("live_before_edge", 2'd3, 1'b0, 4'h4);
        tick(1);
        check("live_update", 2'd3, 1'b0, 4'hE);

        // Reset two cycles into a press; the still-held key must not fire afterwards.
        key_in = 4'b1101;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        check("mid_debounce_rst", 2'd0, 1'b0, 4'h0);
        rst_n = 1'b1;
        tick(20);
        check("held_thru_rst", 2'd0, 1'b0, 4'h1);
        key_in = 4'hF;
        tick(12);
        check("release_after_rst", 2'd0, 1'b0, 4'h1);
        press(4'b1101, 10);
        check("repress_after_rst", 2'd1, 1'b0, 4'h2);

`ifdef LED_AUTOSCAN_EN
        scan_en = 1'b1;
        tick(7);
        check("scan_hold", 2'd1, 1'b0, 4'h2);
        tick(1);
        check("scan_1to2", 2'd2, 1'b0, 4'h2);
        tick(8);
        check("scan_2to3", 2'd3, 1'b0, 4'h3);
        tick(8);
        check("scan_3to0", 2'd0, 1'b0, 4'hE);
        scan_en = 1'b0;
`else
        scan_en = 1'b1;
        tick(40);
        check("scan_ignored", 2'd1, 1'b0, 4'h2);
        scan_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
